mul_32b: RTL and testbench

MUL_32B -- requirements
Module: mul_32b

---
 rtl/mul_32b_pkg.sv | 14 +
 rtl/mul_16x16.sv | 12 +
 rtl/mul_32b.sv | 75 +++++++
 tb/tb_mul_32b.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mul_32b_pkg.sv
// Shared types for the 32x32 pipelined multiplier: the bundle of four
// 16x16 partial products carried between the two pipeline stages.
package mul_32b_pkg;

    localparam int unsigned PP_W = 32;

    typedef struct packed {
        logic [PP_W-1:0] hh;
        logic [PP_W-1:0] hl;
        logic [PP_W-1:0] lh;
        logic [PP_W-1:0] ll;
    } pp_t;

endpackage

// File: rtl/mul_16x16.sv
// Combinational unsigned 16x16 -> 32 multiplier; one partial-product lane.
module mul_16x16
    import mul_32b_pkg::*;
(
    input  logic [15:0]     a_i,
    input  logic [15:0]     b_i,
    output logic [PP_W-1:0] p_o
);

    assign p_o = 32'(a_i) * 32'(b_i);

endmodule

// File: rtl/mul_32b.sv
// Two-stage unsigned 32x32 -> 64 multiplier: partial products registered in
// stage 1, adder tree registered in stage 2. One product per cycle, no stalls.
module mul_32b
    import mul_32b_pkg::*;
#(
    localparam int unsigned OP_W   = 32,
    localparam int unsigned PROD_W = 64,
    localparam int unsigned HALF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in0,
    input  logic [OP_W-1:0]   in1,
    output logic [PROD_W-1:0] out0,
    output logic              out_valid
);

    localparam int unsigned MID_W = OP_W + 1;

    logic [HALF_W-1:0] a_h, a_l, b_h, b_l;
    logic [OP_W-1:0]   pp_ll, pp_lh, pp_hl, pp_hh;
    pp_t               pp_d, pp_p1_q;
    logic              vld_p1_q;
    logic [PROD_W-1:0] prod_d, prod_p2_q;
    logic              vld_p2_q;

    // Middle sum kept at 33 bits so the lh+hl carry is never dropped.
    function automatic logic [PROD_W-1:0] combine(input pp_t pp);
        logic [MID_W-1:0] mid;
        mid = {1'b0, pp.lh} + {1'b0, pp.hl};
        return {pp.hh, {OP_W{1'b0}}}
             + {{(PROD_W-MID_W-HALF_W){1'b0}}, mid, {HALF_W{1'b0}}}
             + {{(PROD_W-OP_W){1'b0}}, pp.ll};
    endfunction

    assign a_h = in0[OP_W-1:HALF_W];
    assign a_l = in0[HALF_W-1:0];
    assign b_h = in1[OP_W-1:HALF_W];
    assign b_l = in1[HALF_W-1:0];

    mul_16x16 u_ll (.a_i(a_l), .b_i(b_l), .p_o(pp_ll));
    mul_16x16 u_lh (.a_i(a_l), .b_i(b_h), .p_o(pp_lh));
    mul_16x16 u_hl (.a_i(a_h), .b_i(b_l), .p_o(pp_hl));
    mul_16x16 u_hh (.a_i(a_h), .b_i(b_h), .p_o(pp_hh));

    assign pp_d   = '{hh: pp_hh, hl: pp_hl, lh: pp_lh, ll: pp_ll};
    assign prod_d = combine(pp_p1_q);

    // Stage 1: partial products and valid tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_p1_q  <= '0;
            vld_p1_q <= 1'b0;
        end else begin
            pp_p1_q  <= pp_d;
            vld_p1_q <= in_valid;
        end
    end

    // Stage 2: summed 64-bit product and valid tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p2_q <= '0;
            vld_p2_q  <= 1'b0;
        end else begin
            prod_p2_q <= prod_d;
            vld_p2_q  <= vld_p1_q;
        end
    end

    assign out0      = prod_p2_q;
    assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_mul_32b.sv
// Scoreboard bench for mul_32b: every issued slot queues its expected
// product and valid tag; a negedge monitor pops and compares when it is due.
module tb_mul_32b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in0, in1;
    logic [63:0] out0;
    logic        out_valid;

    typedef struct {
        int          due;
        bit          v;
        logic [63:0] p;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mul_32b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in0      (in0),
        .in1      (in1),
        .out0     (out0),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain 64-bit unsigned product.
    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
        longint unsigned x, y;
        x = longint'(a);
        y = longint'(b);
        return x * y;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000, 32'h0000_FFFF};
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    // Drive one slot right after a posedge; it is sampled at the next edge
    // and its result is visible after the edge following that.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit v);
        exp_t e;
        in0      = a;
        in1      = b;
        in_valid = v;
        e.due = cyc + 2;
        e.v   = v;
        e.p   = golden(a, b);
        e.a   = a;
        e.b   = b;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        in0      = 32'd5;
        in1      = 32'd7;
        in_valid = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (out0 !== 64'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_clear: out0=%h out_valid=%b, required 0/0", out0, out_valid);
        end
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (out0 !== 64'd0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: out0=%h out_valid=%b, required 0/0", out0, out_valid);
            end
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (out_valid !== e.v || out0 !== e.p) begin
                failures++;
                $display("FAIL product %h*%h: out0=%h out_valid=%b, required %h/%b",
                         e.a, e.b, out0, out_valid, e.p, e.v);
            end
        end else begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_valid at cycle %0d: out_valid=%b, required 0", cyc, out_valid);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in0      = 32'd5;
        in1      = 32'd7;
        in_valid = 1'b1;
        #2;
        do_reset(3);

        // Directed products
        issue(32'd3, 32'd5, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(32'h0001_0000, 32'h0001_0000, 1'b1);
        issue(32'h0, 32'hDEAD_BEEF, 1'b1);
        issue(32'h1234_5678, 32'h0, 1'b1);
        issue(32'h0000_FFFF, 32'hFFFF_0000, 1'b0);

        // Alternating valid with a fixed operand pair
        for (int i = 0; i < 8; i++) issue(32'h8000_0000, 32'h8000_0000, (i % 2) == 0);

        // Two valid products in flight, then a reset pulse discards them
        issue(32'd11, 32'd13, 1'b1);
        issue(32'd17, 32'd19, 1'b1);
        do_reset(2);
        issue(32'd9, 32'd9, 1'b0);
        issue(32'd9, 32'd9, 1'b0);
        issue(32'd21, 32'd2, 1'b1);

        // Random streaming, one pair per cycle
        for (int i = 0; i < 20000; i++) issue(pick(), pick(), $urandom_range(0, 3) != 0);

        issue(32'd0, 32'd0, 1'b0);
        issue(32'd0, 32'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected results never compared, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
